sc_mac_bi_scaled_acc: RTL

Parametrised bipolar stochastic multiply-accumulate unit with a scaled (mux) adder and a built-in stream-to-binary counter. It takes N lanes of W-bit operand pairs and generates per-lane LFSR comparator streams. Each lane is multiplied in bipolar format (XNOR), and one lane is selected per cycle to form the scaled sum. Over a fixed window of 2^LEN_LOG2 cycles it emits the output stream bit-by-bit and accumulates the ones count. Start/done handshake; sits between a binary operand buffer and the downstream layer logic.

---
 rtl/sc_mac_bi_scaled_acc_pkg.sv | 37 +++
 rtl/sc_mac_bi_scaled_acc_if.sv | 22 ++
 rtl/sc_mac_bi_scaled_acc_lane.sv | 41 ++++
 rtl/sc_mac_bi_scaled_acc.sv | 98 +++++++++
 4 files changed

// File: rtl/sc_mac_bi_scaled_acc_pkg.sv
// Shared types and helpers for the bipolar stochastic MAC: FSM states, select-order
// constants, maximal-length LFSR tap masks and the bit-reverse used for van der Corput order.
package sc_mac_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam int SEL_BIN = 0;
  localparam int SEL_VDC = 1;

  // Fibonacci shift-left taps; bit k of the mask feeds back from state bit k.
  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  // Reverse the low nb bits of v (upper bits of v must be zero).
  function automatic logic [5:0] bit_rev(input logic [5:0] v, input int nb);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = v[5-i];
    return r >> (6 - nb);
  endfunction

endpackage

// File: rtl/sc_mac_bi_scaled_acc_if.sv
// Operand/handshake bundle between the operand buffer (master) and the MAC (slave).
interface sc_mac_bi_scaled_acc_if #(
  parameter int N        = 16,
  parameter int W        = 8,
  parameter int LEN_LOG2 = W
);
  logic                  start;
  logic [N-1:0][W-1:0]   iA;
  logic [N-1:0][W-1:0]   iB;
  logic [N-1:0][W-1:0]   iseedA;
  logic [N-1:0][W-1:0]   iseedB;
  logic                  busy;
  logic                  oC;
  logic                  oValid;
  logic                  done;
  logic [LEN_LOG2:0]     oSum;

  modport master (output start, iA, iB, iseedA, iseedB,
                  input  busy, oC, oValid, done, oSum);
  modport slave  (input  start, iA, iB, iseedA, iseedB,
                  output busy, oC, oValid, done, oSum);
endinterface

// File: rtl/sc_mac_bi_scaled_acc_lane.sv
// One bipolar stochastic multiplier lane: latched operands, two LFSR comparators, XNOR.
module sc_lane_mul_bi
  import sc_mac_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_seed_a,
  input  logic [W-1:0] i_seed_b,
  output logic         o_prod
);
  localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

  logic [W-1:0] r_a, r_b, r_lfsr_a, r_lfsr_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_lfsr_a <= '0;
      r_lfsr_b <= '0;
    end else if (i_load) begin
      r_a      <= i_a;
      r_b      <= i_b;
      // zero is the LFSR lock-up state
      r_lfsr_a <= (i_seed_a == '0) ? W'(1) : i_seed_a;
      r_lfsr_b <= (i_seed_b == '0) ? W'(1) : i_seed_b;
    end else if (i_en) begin
      r_lfsr_a <= {r_lfsr_a[W-2:0], ^(r_lfsr_a & TAPS)};
      r_lfsr_b <= {r_lfsr_b[W-2:0], ^(r_lfsr_b & TAPS)};
    end
  end

  assign o_prod = ~((r_lfsr_a <= r_a) ^ (r_lfsr_b <= r_b));

endmodule

// File: rtl/sc_mac_bi_scaled_acc.sv
// Bipolar stochastic MAC: N XNOR lanes, one lane muxed per cycle, ones counted over 2^LEN_LOG2 cycles.
module sc_mac_bi_scaled_acc
  import sc_mac_pkg::*;
#(
  parameter int N        = 16,
  parameter int W        = 8,
  parameter int LEN_LOG2 = W,
  parameter int SEL_MODE = SEL_VDC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sc_mac_bi_scaled_acc_if.slave bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  state_e              r_state;
  logic [LEN_LOG2-1:0] r_idx;
  logic [SW-1:0]       r_cnt;
  logic [LEN_LOG2:0]   r_acc;
  logic                r_busy, r_oc, r_ovalid, r_done;
  logic [N-1:0]        w_prod;
  logic [SW-1:0]       w_sel;
  logic                w_load, w_en, w_bit;

  // start is only honoured outside RUN
  assign w_load = bus.start && (r_state != S_RUN);
  assign w_en   = (r_state == S_RUN);

  for (genvar i = 0; i < N; i++) begin : g_lane
    sc_lane_mul_bi #(.W(W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load),
      .i_en     (w_en),
      .i_a      (bus.iA[i]),
      .i_b      (bus.iB[i]),
      .i_seed_a (bus.iseedA[i]),
      .i_seed_b (bus.iseedB[i]),
      .o_prod   (w_prod[i])
    );
  end

  if (SEL_MODE == SEL_VDC) begin : g_sel_vdc
    assign w_sel = SW'(bit_rev(6'(r_cnt), SW));
  end else begin : g_sel_bin
    assign w_sel = r_cnt;
  end

  assign w_bit = w_prod[w_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_oc     <= 1'b0;
      r_ovalid <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_ovalid <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_RUN: begin
          r_acc    <= r_acc + (LEN_LOG2+1)'(w_bit);
          r_oc     <= w_bit;
          r_ovalid <= 1'b1;
          r_cnt    <= r_cnt + 1'b1;
          r_idx    <= r_idx + 1'b1;
          if (r_idx == '1) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          if (bus.start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.oC     = r_oc;
  assign bus.oValid = r_ovalid;
  assign bus.done   = r_done;
  assign bus.oSum   = r_acc;

endmodule
